// File: rtl/store_narrow_unit.sv
// Narrow store unit: turns SB/SH/SW pipeline stores into lane-replicated word writes with
// byte enables, a bounded ack wait, and error pulses. Define MISALIGN_TRAP_EN to trap misaligned stores.
module store_narrow_unit #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_size,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  output logic        st_done,
  output logic        st_err,
  output logic [1:0]  err_code
);

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {StIdle, StReq, StFin, StErr} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  err_q, err_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;

  logic [1:0]  bad_code;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_be;

  // Classify the incoming request; nonzero means it goes straight to ERR.
  always_comb begin
    bad_code = 2'b00;
    if (st_size == 2'b11) begin
      bad_code = 2'b11;
    end
`ifdef MISALIGN_TRAP_EN
    else if ((st_size == 2'b01 && st_addr[0]) || (st_size == 2'b10 && st_addr[1:0] != 2'b00)) begin
      bad_code = 2'b01;
    end
`endif
  end

  always_comb begin
    lane_wdata = st_data;
    lane_be    = 4'b1111;
    case (st_size)
      2'b00: begin
        lane_wdata = {4{st_data[7:0]}};
        lane_be    = 4'b0001 << st_addr[1:0];
      end
      2'b01: begin
        lane_wdata = {2{st_data[15:0]}};
        lane_be    = st_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    unique case (state_q)
      StIdle: begin
        if (st_valid) begin
          if (bad_code != 2'b00) begin
            state_d = StErr;
            err_d   = bad_code;
          end else begin
            state_d = StReq;
            cnt_d   = 8'd0;
            addr_d  = {st_addr[31:2], 2'b00};
            wdata_d = lane_wdata;
            be_d    = lane_be;
          end
        end
      end
      StReq: begin
        // Ack beats the timeout when both land on the same edge.
        if (mem_ack) begin
          state_d = StFin;
        end else if (cnt_q == TimeoutLast) begin
          state_d = StErr;
          err_d   = 2'b10;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StFin:   state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      err_q   <= 2'b00;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  assign st_ready  = (state_q == StIdle);
  assign mem_req   = (state_q == StReq);
  assign st_done   = (state_q == StFin);
  assign st_err    = (state_q == StErr);
  assign err_code  = st_err ? err_q : 2'b00;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;

endmodule

// File: tb/tb_store_narrow_unit.sv
// Bench for store_narrow_unit: directed and random stores checked against an arithmetic model.
// Define MISALIGN_TRAP_EN here as for the RTL to check the trapping build.
module tb_store_narrow_unit;
  localparam int unsigned T = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        st_done;
  logic        st_err;
  logic [1:0]  err_code;

  int tests = 0;
  int fails = 0;

  logic [31:0] last_addr;
  logic [31:0] last_wdata;
  logic [3:0]  last_be;
  int          last_nreq;
  int          last_done_c;
  int          last_err_c;
  logic [1:0]  last_code;

  store_narrow_unit #(.TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_data(st_data), .st_size(st_size), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack), .st_done(st_done),
    .st_err(st_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected write from plain arithmetic on the store's byte address and size.
  function automatic void model(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                                output logic [31:0] ea, output logic [31:0] ew,
                                output logic [3:0] eb, output logic [1:0] ill);
    int unsigned off;
    off = a % 4;
    ea  = a - off;
    ill = 2'd0;
    case (sz)
      2'd0: begin
        ew = (d & 32'hFF) * 32'h01010101;
        eb = 4'(1 << off);
      end
      2'd1: begin
        ew = (d & 32'hFFFF) * 32'h00010001;
        eb = 4'(3 << (2 * (off / 2)));
`ifdef MISALIGN_TRAP_EN
        if (off % 2 != 0) ill = 2'd1;
`endif
      end
      2'd2: begin
        ew = d;
        eb = 4'hF;
`ifdef MISALIGN_TRAP_EN
        if (off != 0) ill = 2'd1;
`endif
      end
      default: begin
        ew  = 32'd0;
        eb  = 4'd0;
        ill = 2'd3;
      end
    endcase
  endfunction

  // ackj: cycle after the handshake (1-based) in which mem_ack is high; 0 means never.
  task automatic run_store(input string tag, input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] sz, input int ackj);
    logic [31:0] ea, ew;
    logic [3:0]  eb;
    logic [1:0]  ill, exp_code;
    int exp_req, exp_done, exp_err;
    model(a, d, sz, ea, ew, eb, ill);
    if (ill != 2'd0) begin
      exp_req = 0; exp_done = 0; exp_err = 1; exp_code = ill;
    end else if (ackj >= 1 && ackj <= int'(T)) begin
      exp_req = ackj; exp_done = ackj + 1; exp_err = 0; exp_code = 2'd0;
    end else begin
      exp_req = T; exp_done = 0; exp_err = T + 1; exp_code = 2'd2;
    end
    @(negedge clk);
    check({tag, " ready"}, 32'(st_ready), 32'd1);
    st_valid = 1'b1; st_addr = a; st_data = d; st_size = sz;
    @(negedge clk);
    // Scramble the inputs so a missing capture would show up.
    st_valid = 1'b0; st_addr = $urandom; st_data = $urandom; st_size = 2'($urandom);
    last_nreq = 0; last_done_c = 0; last_err_c = 0; last_code = 2'd0;
    for (int c = 1; c <= int'(T) + 4 && last_done_c == 0 && last_err_c == 0; c++) begin
      if (c > 1) @(negedge clk);
      mem_ack = (c == ackj);
      if (mem_req) begin
        last_nreq++;
        last_addr = mem_addr; last_wdata = mem_wdata; last_be = mem_be;
        check({tag, " addr"}, mem_addr, ea);
        check({tag, " wdata"}, mem_wdata, ew);
        check({tag, " be"}, 32'(mem_be), 32'(eb));
      end
      check({tag, " done_err_excl"}, 32'(st_done & st_err), 32'd0);
      if (!st_err) check({tag, " code_idle"}, 32'(err_code), 32'd0);
      if (st_done) last_done_c = c;
      if (st_err) begin
        last_err_c = c;
        last_code  = err_code;
      end
    end
    mem_ack = 1'b0;
    check({tag, " nreq"}, 32'(last_nreq), 32'(exp_req));
    check({tag, " done_cyc"}, 32'(last_done_c), 32'(exp_done));
    check({tag, " err_cyc"}, 32'(last_err_c), 32'(exp_err));
    check({tag, " err_code"}, 32'(last_code), 32'(exp_code));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = '0; mem_ack = 1'b0;
    #2;
    check("rst ready", 32'(st_ready), 32'd1);
    check("rst mem_req", 32'(mem_req), 32'd0);
    check("rst be", 32'(mem_be), 32'd0);
    check("rst addr", mem_addr, 32'd0);
    check("rst wdata", mem_wdata, 32'd0);
    check("rst pulses", 32'({st_done, st_err, err_code}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Stray ack while idle must do nothing.
    mem_ack = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("idle_ack req", 32'(mem_req), 32'd0);
      check("idle_ack pulses", 32'({st_done, st_err}), 32'd0);
      check("idle_ack ready", 32'(st_ready), 32'd1);
    end
    mem_ack = 1'b0;

    // Memory registers its ack, so a zero-wait response lands in the second mem_req cycle.
    run_store("sb", 32'h1003, 32'h000000AB, 2'd0, 3);
    check("sb lit addr", last_addr, 32'h1000);
    check("sb lit wdata", last_wdata, 32'hABABABAB);
    check("sb lit be", 32'(last_be), 32'h8);

    run_store("sh", 32'h2002, 32'h1234BEEF, 2'd1, 2);
    check("sh lit wdata", last_wdata, 32'hBEEFBEEF);
    check("sh lit be", 32'(last_be), 32'hC);
    check("sh lit done_cyc", 32'(last_done_c), 32'd3);

    run_store("sw_to", 32'h3000, 32'hDEADBEEF, 2'd2, 0);
    check("sw_to lit nreq", 32'(last_nreq), 32'd16);
    check("sw_to lit code", 32'(last_code), 32'd2);

    run_store("ack_at_limit", 32'h3004, 32'h01020304, 2'd2, int'(T));
    run_store("ack_late", 32'h3008, 32'h05060708, 2'd2, int'(T) + 1);

    run_store("sw_mis", 32'h3002, 32'hCAFEF00D, 2'd2, 1);
`ifdef MISALIGN_TRAP_EN
    check("sw_mis lit code", 32'(last_code), 32'd1);
    check("sw_mis lit nreq", 32'(last_nreq), 32'd0);
`else
    check("sw_mis lit addr", last_addr, 32'h3000);
    check("sw_mis lit be", 32'(last_be), 32'hF);
    check("sw_mis lit done", 32'(last_done_c), 32'd2);
`endif

    run_store("bad_size", 32'h4000, 32'h11111111, 2'd3, 1);
    check("bad_size lit code", 32'(last_code), 32'd3);

    // Reset while mem_req is high abandons the store silently.
    @(negedge clk);
    st_valid = 1'b1; st_addr = 32'h5000; st_data = 32'h87654321; st_size = 2'd2;
    @(negedge clk);
    st_valid = 1'b0;
    @(negedge clk);
    check("mid_rst req_before", 32'(mem_req), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst req", 32'(mem_req), 32'd0);
    check("mid_rst be", 32'(mem_be), 32'd0);
    check("mid_rst addr", mem_addr, 32'd0);
    check("mid_rst pulses", 32'({st_done, st_err, err_code}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst ready", 32'(st_ready), 32'd1);
      check("post_rst pulses", 32'({mem_req, st_done, st_err}), 32'd0);
    end

    for (int i = 0; i < 25; i++) begin
      logic [1:0] sz;
      int ackj;
      sz   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      ackj = $urandom_range(0, int'(T) + 2);
      run_store($sformatf("rnd%0d", i), $urandom, $urandom, sz, ackj);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
